// File: rtl/strum_sequencer_if.sv
// strum_sequencer_if: host message input and downstream message bus
// shared between the host driver and the strum sequencer.
interface strum_sequencer_if;
  logic        host_en;
  logic [31:0] host_addr;
  logic [31:0] host_data;
  logic        msg_en;
  logic [31:0] msg_addr;
  logic [31:0] msg;
  logic        busy;

  modport slave (
    input  host_en,
    input  host_addr,
    input  host_data,
    output msg_en,
    output msg_addr,
    output msg,
    output busy
  );

  modport master (
    output host_en,
    output host_addr,
    output host_data,
    input  msg_en,
    input  msg_addr,
    input  msg,
    input  busy
  );
endinterface

// File: rtl/strum_sequencer.sv
// strum_sequencer: shares the message bus between host and a strum engine.
// Define STRUM_REPEAT_EN to honour the repeat bit (data[24]) of control.
module strum_sequencer #(
  parameter logic [31:0] SEQ_BASE    = 32'h3000_0100,
  parameter logic [31:0] TARGET_BASE = 32'h3000_0000,
  parameter int unsigned SLOTS       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lrck,
  strum_sequencer_if.slave  bus
);
  localparam logic [3:0] SLOTS_W = 4'(SLOTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] slot_q [SLOTS];
  logic [31:0] slot_d [SLOTS];
  logic [15:0] gap_q, gap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  idx_q, idx_d;
  logic        rpt_q, rpt_d;
  logic        lrck_q;
  logic        msg_en_q, msg_en_d;
  logic [31:0] msg_addr_q, msg_addr_d;
  logic [31:0] msg_q, msg_d;
  logic        busy_q, busy_d;

  logic [31:0] off;
  logic        in_win;
  logic        fwd;
  logic        ctrl_wr;
  logic        slot_wr;
  logic        lr_rise;
  logic        issue;
  logic        last;
  logic [3:0]  count_in;
  logic [3:0]  count_cl;
  logic        rpt_in;

  // Unsigned offset: addresses below the base wrap to huge values.
  assign off      = bus.host_addr - SEQ_BASE;
  assign in_win   = off <= 32'd8;
  assign lr_rise  = lrck & ~lrck_q;
  assign count_in = bus.host_data[19:16];
  assign count_cl = (count_in > SLOTS_W) ? SLOTS_W : count_in;
  assign last     = ({1'b0, idx_q} == (count_q - 4'd1));
  assign issue    = (state_q == EMIT) && !fwd && !ctrl_wr;

`ifdef STRUM_REPEAT_EN
  assign rpt_in = bus.host_data[24];
`else
  assign rpt_in = 1'b0;
`endif

  always_comb begin
    fwd     = 1'b0;
    ctrl_wr = 1'b0;
    slot_wr = 1'b0;
    if (bus.host_en) begin
      unique case (1'b1)
        !in_win:           fwd     = 1'b1;
        in_win && off[3]:  ctrl_wr = 1'b1;
        in_win && !off[3]: slot_wr = {1'b0, off[2:0]} < SLOTS_W;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    idx_d      = idx_q;
    rpt_d      = rpt_q;
    msg_en_d   = 1'b0;
    msg_addr_d = msg_addr_q;
    msg_d      = msg_q;

    for (int i = 0; i < SLOTS; i++) begin
      if (slot_wr && (off[2:0] == 3'(i))) begin
        slot_d[i] = bus.host_data;
      end
    end

    if (fwd) begin
      msg_en_d   = 1'b1;
      msg_addr_d = bus.host_addr;
      msg_d      = bus.host_data;
    end

    unique case (state_q)
      EMIT: begin
        if (issue) begin
          msg_en_d   = 1'b1;
          msg_addr_d = TARGET_BASE + 32'(idx_q);
          msg_d      = slot_q[idx_q];
          if (last && !rpt_q) begin
            state_d = IDLE;
          end else begin
            idx_d   = last ? 3'd0 : idx_q + 3'd1;
            cnt_d   = gap_q;
            state_d = (gap_q == 16'd0) ? EMIT : WAIT;
          end
        end
      end
      WAIT: begin
        if (lr_rise) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = EMIT;
          end
        end
      end
      default: ;
    endcase

    // A control write overrides whatever the engine planned this cycle.
    if (ctrl_wr) begin
      gap_d   = bus.host_data[15:0];
      count_d = count_cl;
      rpt_d   = rpt_in;
      if (count_cl == 4'd0) begin
        state_d = IDLE;
      end else begin
        idx_d   = 3'd0;
        state_d = EMIT;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      gap_q      <= '0;
      cnt_q      <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      rpt_q      <= 1'b0;
      lrck_q     <= 1'b0;
      msg_en_q   <= 1'b0;
      msg_addr_q <= '0;
      msg_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      rpt_q      <= rpt_d;
      lrck_q     <= lrck;
      msg_en_q   <= msg_en_d;
      msg_addr_q <= msg_addr_d;
      msg_q      <= msg_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.msg_en   = msg_en_q;
  assign bus.msg_addr = msg_addr_q;
  assign bus.msg      = msg_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_strum_sequencer.sv
// tb_strum_sequencer: directed scenarios plus random traffic, checked
// every cycle against an event-level model of the strum sequencer.
module tb_strum_sequencer;
  localparam logic [31:0] SEQ = 32'h3000_0100;
  localparam logic [31:0] TGT = 32'h3000_0000;
  localparam int          SL  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lrck = 1'b0;

  strum_sequencer_if bus();

  strum_sequencer #(
    .SEQ_BASE    (SEQ),
    .TARGET_BASE (TGT),
    .SLOTS       (SL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lrck  (lrck),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } ev_t;

  ev_t evs[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc = 0;
  logic lr = 1'b0;
  logic rs = 1'b0;

  // Model: expected outputs plus strum progress in event terms.
  logic        m_en, m_busy;
  logic [31:0] m_addr, m_msg;
  logic [31:0] m_slot [8];
  int          m_gap, m_cnt, m_pos, m_need;
  bit          m_rep, m_active, m_lr;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_en = 0; m_busy = 0; m_addr = 0; m_msg = 0;
    for (int i = 0; i < 8; i++) m_slot[i] = 0;
    m_gap = 0; m_cnt = 0; m_pos = 0; m_need = 0;
    m_rep = 0; m_active = 0; m_lr = 0;
  endfunction

  function automatic void model_step(logic en, logic [31:0] a,
                                     logic [31:0] d, logic l, logic r);
    bit rise, loc, fwd, ctl;
    int off, c;
    if (!r) begin
      model_reset();
      return;
    end
    rise = l && !m_lr;
    m_lr = l;
    loc  = en && (a >= SEQ) && (a <= SEQ + 32'd8);
    fwd  = en && !loc;
    off  = int'(a - SEQ);
    ctl  = loc && off == 8;
    m_en = 0;
    if (fwd) begin
      m_en = 1; m_addr = a; m_msg = d;
    end
    if (m_active && !ctl) begin
      if (m_need == 0) begin
        if (!fwd) begin
          m_en   = 1;
          m_addr = TGT + 32'(m_pos);
          m_msg  = m_slot[m_pos];
          m_pos++;
          m_need = m_gap;
          if (m_pos == m_cnt) begin
            if (m_rep) m_pos = 0;
            else m_active = 0;
          end
        end
      end else if (rise) begin
        m_need--;
      end
    end
    if (loc && off < SL) m_slot[off] = d;
    if (ctl) begin
      m_gap = int'(d[15:0]);
      c = int'(d[19:16]);
      if (c > SL) c = SL;
      m_cnt = c;
`ifdef STRUM_REPEAT_EN
      m_rep = d[24];
`else
      m_rep = 0;
`endif
      if (c == 0) m_active = 0;
      else begin
        m_active = 1; m_pos = 0; m_need = 0;
      end
    end
    m_busy = m_active;
  endfunction

  task automatic tick(input logic en, input logic [31:0] a,
                      input logic [31:0] d);
    bus.host_en   = en;
    bus.host_addr = a;
    bus.host_data = d;
    lrck  = lr;
    rst_n = rs;
    model_step(en, a, d, lr, rs);
    @(posedge clk);
    @(negedge clk);
    chk("msg_en", 32'(bus.msg_en), 32'(m_en));
    chk("msg_addr", bus.msg_addr, m_addr);
    chk("msg", bus.msg, m_msg);
    chk("busy", 32'(bus.busy), 32'(m_busy));
    if (bus.msg_en === 1'b1) evs.push_back('{bus.msg_addr, bus.msg, cyc});
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 32'h0);
  endtask

  task automatic pulse_lr(input int n);
    for (int i = 0; i < n; i++) begin
      lr = 1'b1; idle(1);
      lr = 1'b0; idle(1);
    end
  endtask

  initial begin
    int c0, sz;
    logic [31:0] a, d;
    int r;
    bus.host_en = 0; bus.host_addr = 0; bus.host_data = 0;
    model_reset();
    @(negedge clk);
    rs = 1'b0;
    idle(3);
    rs = 1'b1;
    idle(2);
    chk("rst_en", 32'(bus.msg_en), 32'h0);
    chk("rst_addr", bus.msg_addr, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    tick(1'b1, 32'h3000_0002, 32'h1234);
    chk("fwd_en", 32'(bus.msg_en), 32'h1);
    chk("fwd_addr", bus.msg_addr, 32'h3000_0002);
    chk("fwd_data", bus.msg, 32'h1234);
    chk("fwd_busy", 32'(bus.busy), 32'h0);
    idle(1);

    for (int i = 0; i < 6; i++) tick(1'b1, SEQ + 32'(i), 32'hA0 + 32'(i));
    evs.delete();
    c0 = cyc;
    tick(1'b1, SEQ + 32'd8, 32'h0003_0002);
    idle(1);
    chk("strum_first_lat", 32'(evs[0].c - c0), 32'd1);
    chk("strum_e0", evs[0].d, 32'hA0);
    pulse_lr(1);
    lr = 1'b1; idle(1);
    chk("strum_gap_hold", 32'(evs.size()), 32'd1);
    lr = 1'b0; idle(1);
    chk("strum_e1_cnt", 32'(evs.size()), 32'd2);
    chk("strum_e1_addr", evs[1].a, TGT + 32'd1);
    pulse_lr(2);
    chk("strum_e2_data", evs[2].d, 32'hA2);
    chk("strum_busy_fall", 32'(bus.busy), 32'h0);
    pulse_lr(3);
    chk("strum_total", 32'(evs.size()), 32'd3);

    evs.delete();
    tick(1'b1, SEQ + 32'd8, 32'h0001_0000);
    tick(1'b1, 32'h3000_0004, 32'hC1);
    tick(1'b1, 32'h3000_0005, 32'hC2);
    tick(1'b1, 32'h3000_0006, 32'hC3);
    idle(3);
    chk("coll_cnt", 32'(evs.size()), 32'd4);
    chk("coll_h0", evs[0].d, 32'hC1);
    chk("coll_slot_addr", evs[3].a, TGT);
    chk("coll_slot_data", evs[3].d, 32'hA0);
    chk("coll_slot_lat", 32'(evs[3].c - evs[2].c), 32'd1);

    evs.delete();
    tick(1'b1, SEQ + 32'd8, 32'h0006_0004);
    idle(1);
    pulse_lr(4);
    chk("abort_two", 32'(evs.size()), 32'd2);
    tick(1'b1, SEQ + 32'd8, 32'h0000_0000);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    pulse_lr(10);
    chk("abort_quiet", 32'(evs.size()), 32'd2);
    chk("abort_e1", evs[1].d, 32'hA1);
    tick(1'b1, SEQ + 32'd8, 32'h0001_0000);
    idle(2);
    chk("restart_addr", evs[2].a, TGT);
    chk("restart_data", evs[2].d, 32'hA0);

    evs.delete();
    tick(1'b1, SEQ + 32'd8, 32'h000F_0000);
    tick(1'b1, SEQ + 32'd6, 32'hDEAD);
    tick(1'b1, SEQ + 32'd7, 32'hBEEF);
    idle(8);
    chk("clamp_cnt", 32'(evs.size()), 32'd6);
    chk("clamp_last", evs[5].a, TGT + 32'd5);
    chk("clamp_data", evs[5].d, 32'hA5);
    chk("clamp_b2b", 32'(evs[5].c - evs[0].c), 32'd5);

    tick(1'b1, SEQ + 32'd8, 32'h0006_0000);
    idle(1);
    rs = 1'b0; idle(1); rs = 1'b1;
    chk("mrst_en", 32'(bus.msg_en), 32'h0);
    chk("mrst_busy", 32'(bus.busy), 32'h0);
    sz = evs.size();
    idle(8);
    chk("mrst_quiet", 32'(evs.size()), 32'(sz));

    tick(1'b1, SEQ, 32'hE0);
    tick(1'b1, SEQ + 32'd1, 32'hE1);
    evs.delete();
    tick(1'b1, SEQ + 32'd8, 32'h0102_0001);
    idle(1);
    pulse_lr(4);
`ifdef STRUM_REPEAT_EN
    chk("rep_cnt", 32'(evs.size()), 32'd5);
    chk("rep_wrap", evs[2].a, TGT);
    chk("rep_next", evs[3].a, TGT + 32'd1);
`else
    chk("norep_cnt", 32'(evs.size()), 32'd2);
    chk("norep_last", evs[1].d, 32'hE1);
`endif
    tick(1'b1, SEQ + 32'd8, 32'h0);
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      r  = int'($urandom_range(0, 99));
      lr = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      d  = $urandom;
      if (r < 15) begin
        a = ($urandom_range(0, 1) == 0) ? TGT + 32'($urandom_range(0, 15))
                                        : $urandom;
        tick(1'b1, a, d);
      end else if (r < 25) begin
        tick(1'b1, SEQ + 32'($urandom_range(0, 7)), d);
      end else if (r < 28) begin
        d[19:16] = 4'($urandom_range(0, 15));
        d[15:0]  = 16'($urandom_range(0, 3));
        tick(1'b1, SEQ + 32'd8, d);
      end else begin
        tick(1'b0, $urandom, d);
      end
      rs = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/strum_sequencer.md
# strum_sequencer

Sequences plucks onto the shared single-cycle message bus (`msg_en`/`msg_addr`/`msg`) that feeds the guitar synth and the DAC, and shares that bus between the host and an autonomous strum engine. The host programs up to SLOTS pluck payloads plus a gap and count. The block then emits them one by one, spaced by a programmable number of `lrck` rising edges, to play a strummed chord. Host traffic always has priority, and strum emissions are deferred around it.

## Interface
- SEQ_BASE, 32'h3000_0100: base of the block's own host address window (slots at +0..+SLOTS-1, control at +8)
- TARGET_BASE, 32'h3000_0000: downstream address of slot i's emission is TARGET_BASE+i
- SLOTS, 6: number of pluck slots, legal 1..8
- clk  input  1  system clock, the only clock
- rst_n  input  1  reset; synchronous, active-low
- lrck  input  1  sample-rate clock from the DAC, generated in the clk domain (no synchronizer)
- host_en  input  1  single-cycle host message strobe
- host_addr  input  32  host message address
- host_data  input  32  host message payload
- msg_en  output  1  downstream message strobe, registered
- msg_addr  output  32  downstream message address, registered
- msg  output  32  downstream message payload, registered
- busy  output  1  high whenever the state is not IDLE, registered

## Operation
- **Decode.** A host message is "local" when host_addr is in SEQ_BASE..SEQ_BASE+8; all others are "forwarded".
  - Local messages are consumed and never appear downstream.
  - Local addresses +SLOTS..+7 are ignored.
- **Slot write** (SEQ_BASE+i, i<SLOTS): slot[i] <= host_data.
  - Legal at any time.
  - Affects a running strum only if slot i has not yet been emitted.
- **Control write** (SEQ_BASE+8) fields:
  - gap = data[15:0]
  - count = data[19:16], clamped to SLOTS if larger
  - repeat = data[24]
- **Control write with count=0:** stop, go to IDLE, no emission.
- **Control write with count>0:** abort any strum in progress, index<=0, go to EMIT.
- **States:**
  - IDLE → EMIT on control write with count>0.
  - EMIT: in a cycle where no forwarded host message is accepted, issue slot[index] to TARGET_BASE+index. After the issue:
    - if index=count-1 and not repeating → IDLE
    - else advance index (wrapping to 0 when repeating), load gap counter with gap, and go to WAIT (or stay in EMIT if gap=0)
  - WAIT: decrement the counter on each detected lrck rising edge. When it reaches 0, go to EMIT.
- **lrck edge detect:** lrck_q register; an edge is detected in the cycle where lrck=1 and lrck_q=0.
- **Arbitration:** a forwarded host message and a strum issue in the same cycle → host wins, strum stays in EMIT and retries next cycle. There is no host backpressure; consecutive host messages can starve the strum indefinitely.
- **Idle bus:** when nothing is issued, msg_en=0 and msg_addr/msg hold their last values.

## Timing
- Reset values:
  - msg_en=0, msg_addr=0, msg=0, busy=0, state IDLE
  - all slots=0, gap=0, count=0, index=0, lrck_q=0
- Reset mid-strum aborts immediately; no further emissions.
- Host forward latency: host_en at cycle t → msg_en=1 at t+1 with identical addr/data.
- Start latency: control write at t → EMIT at t+1 → first emission msg_en at t+2, if no forward is accepted at t+1.
- Gap G≥1: the next issue happens in the cycle after the G-th detected lrck rising edge following the previous issue, plus any host-induced deferral.
- Gap 0: back-to-back emissions on consecutive cycles.
- busy rises at t+1 after a start write. It falls in the cycle after the last issue, i.e. with the last msg_en pulse.
- Control write in the same cycle as a pending strum issue: the control write wins, and the issue is not performed.

## Configuration
- STRUM_REPEAT_EN defined:
  - The repeat bit is honoured. After slot count-1 the block waits gap edges and loops to slot 0 indefinitely, until a stop or new control write.
  - With repeat=1 and gap=0 it loops every cycle.
- STRUM_REPEAT_EN undefined:
  - data[24] is ignored, and every strum ends after count issues.

## Test plan
- **Reset/forward:** release reset; host_en at t with addr 32'h3000_0002, data 32'h1234 → msg_en at t+1 with same addr/data; busy=0; outputs 0 before the first message.
- **Basic strum:** write slots 0..2 = 32'hA0..A2, then control gap=2, count=3; toggle lrck.
  - Emissions (TARGET_BASE+0, A0), (+1, A1), (+2, A2), each one cycle after the 2nd lrck rise following the previous emission.
  - busy falls with the third emission.
- **Collision:** during EMIT, drive forwarded host messages for 3 consecutive cycles → three host messages appear first, then the slot emission one cycle later.
- **Abort/stop:** start count=6, gap=4; after 2 emissions write control count=0 → busy=0 next cycle, no further strum messages. A new start restarts at slot 0.
- **Clamp/local:** SLOTS=6, control count=15, gap=0 → exactly 6 back-to-back emissions. Writes to SEQ_BASE+6/+7 never appear downstream.
- **Repeat (STRUM_REPEAT_EN):** count=2, gap=1, repeat=1 → slot sequence 0,1,0,1,… until stop.
